// File: rtl/switch_allocator_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg: shared types and constants for the router switch allocator.
//   NUM_OF_PORTS : number of router input/output ports
//   port_id_t    : 3-bit port identifier
//   NONE_PORT    : "no route" id; never matches a real output
//   sa_state_t   : per-output allocation FSM state
//   next_port()  : increment a port id with wrap-around at NUM_OF_PORTS-1
// Optional feature macro used elsewhere: SW_ALLOC_STATS_EN.
// -----------------------------------------------------------------------------
package router_pkg;

    localparam int unsigned NUM_OF_PORTS = 5;
    localparam int unsigned PORT_W       = 3;

    typedef logic [PORT_W-1:0] port_id_t;

    localparam port_id_t NONE_PORT = 3'd7;

    typedef enum logic {
        O_IDLE,
        O_LOCKED
    } sa_state_t;

    function automatic port_id_t next_port(input port_id_t p);
        return (p == port_id_t'(NUM_OF_PORTS - 1)) ? '0 : p + port_id_t'(1);
    endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// -----------------------------------------------------------------------------
// switch_allocator_if: input-port requests, crossbar control and status of the
// switch allocator.
//   i_req / i_target_port / i_tail : head-of-buffer flit per input port
//   i_credit_ret                   : downstream slot freed, per output port
//   o_in_grant                     : flit consumed this cycle, per input port
//   o_xbar_valid / o_xbar_sel      : registered crossbar control, per output
//   o_credit_err                   : sticky credit overflow flag
//   o_pkt_cnt                      : completed packets per output
//                                    (only with SW_ALLOC_STATS_EN defined)
// Modports: master drives the requests (router side), slave is the allocator.
// -----------------------------------------------------------------------------
interface switch_allocator_if;
    import router_pkg::*;

    logic [NUM_OF_PORTS-1:0] i_req;
    port_id_t                i_target_port [NUM_OF_PORTS];
    logic [NUM_OF_PORTS-1:0] i_tail;
    logic [NUM_OF_PORTS-1:0] i_credit_ret;
    logic [NUM_OF_PORTS-1:0] o_in_grant;
    logic [NUM_OF_PORTS-1:0] o_xbar_valid;
    port_id_t                o_xbar_sel    [NUM_OF_PORTS];
    logic                    o_credit_err;
`ifdef SW_ALLOC_STATS_EN
    logic [15:0]             o_pkt_cnt     [NUM_OF_PORTS];
`endif

    modport master (
`ifdef SW_ALLOC_STATS_EN
        input  o_pkt_cnt,
`endif
        output i_req, i_target_port, i_tail, i_credit_ret,
        input  o_in_grant, o_xbar_valid, o_xbar_sel, o_credit_err
    );

    modport slave (
`ifdef SW_ALLOC_STATS_EN
        output o_pkt_cnt,
`endif
        input  i_req, i_target_port, i_tail, i_credit_ret,
        output o_in_grant, o_xbar_valid, o_xbar_sel, o_credit_err
    );

endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter: combinational round-robin arbiter.
//   req : request vector, one bit per input port
//   ptr : highest-priority input; search goes upward and wraps to 0
//   gnt : one-hot grant (all zero when no request)
// ptr must be below NUM_OF_PORTS.
// -----------------------------------------------------------------------------
module rr_arbiter
    import router_pkg::*;
(
    input  logic [NUM_OF_PORTS-1:0] req,
    input  port_id_t                ptr,
    output logic [NUM_OF_PORTS-1:0] gnt
);

    port_id_t idx;
    logic     found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = ptr;
        for (int k = 0; k < NUM_OF_PORTS; k++) begin
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
            idx = next_port(idx);
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// -----------------------------------------------------------------------------
// switch_allocator: wormhole switch allocator with per-output credit tracking.
// Each output runs an O_IDLE/O_LOCKED FSM: in O_IDLE a round-robin arbiter
// picks among eligible inputs; a non-tail grant locks the output to that input
// until its tail flit is granted. Grants need a non-zero output credit.
//   clk, rst_n : clock, synchronous active-low reset
//   sa         : switch_allocator_if.slave (requests, grants, xbar control)
// Parameters: CREDIT_DEPTH (downstream slots per output), CNT_W (counter width).
// Macro SW_ALLOC_STATS_EN adds saturating per-output completed-packet counters.
// -----------------------------------------------------------------------------
module switch_allocator
    import router_pkg::*;
#(
    parameter int unsigned CREDIT_DEPTH = 4,
    parameter int unsigned CNT_W        = $clog2(CREDIT_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    switch_allocator_if.slave  sa
);

    localparam logic [CNT_W-1:0] CreditFull = CNT_W'(CREDIT_DEPTH);

    sa_state_t               state_q  [NUM_OF_PORTS];
    sa_state_t               state_d  [NUM_OF_PORTS];
    port_id_t                owner_q  [NUM_OF_PORTS];
    port_id_t                owner_d  [NUM_OF_PORTS];
    port_id_t                rr_q     [NUM_OF_PORTS];
    port_id_t                rr_d     [NUM_OF_PORTS];
    logic [CNT_W-1:0]        credit_q [NUM_OF_PORTS];
    logic [CNT_W-1:0]        credit_d [NUM_OF_PORTS];
    port_id_t                sel_q    [NUM_OF_PORTS];
    port_id_t                sel_d    [NUM_OF_PORTS];
    logic [NUM_OF_PORTS-1:0] valid_q, valid_d;
    logic                    err_q, err_d;

    // elig[p][i]: input i may be granted by output p this cycle
    logic [NUM_OF_PORTS-1:0] elig     [NUM_OF_PORTS];
    logic [NUM_OF_PORTS-1:0] arb_gnt  [NUM_OF_PORTS];
    logic [NUM_OF_PORTS-1:0] gnt      [NUM_OF_PORTS];
    port_id_t                gnt_idx  [NUM_OF_PORTS];
    logic [NUM_OF_PORTS-1:0] in_grant;

`ifdef SW_ALLOC_STATS_EN
    logic [15:0]             pkt_q    [NUM_OF_PORTS];
    logic [15:0]             pkt_d    [NUM_OF_PORTS];
`endif

    // Invalid target ids can never equal a real output index, so they drop out here.
    always_comb begin
        for (int p = 0; p < NUM_OF_PORTS; p++) begin
            for (int i = 0; i < NUM_OF_PORTS; i++) begin
                elig[p][i] = sa.i_req[i] && (sa.i_target_port[i] == port_id_t'(p)) &&
                             (credit_q[p] != '0);
            end
        end
    end

    for (genvar p = 0; p < NUM_OF_PORTS; p++) begin : g_arb
        rr_arbiter u_rr_arbiter (
            .req (elig[p]),
            .ptr (rr_q[p]),
            .gnt (arb_gnt[p])
        );
    end

    // Each input names a single target, so the per-output grants never overlap.
    always_comb begin
        in_grant = '0;
        for (int p = 0; p < NUM_OF_PORTS; p++) begin
            gnt[p]     = '0;
            gnt_idx[p] = '0;
            if (rst_n) begin
                if (state_q[p] == O_IDLE) begin
                    gnt[p] = arb_gnt[p];
                end else if (elig[p][owner_q[p]]) begin
                    gnt[p][owner_q[p]] = 1'b1;
                end
            end
            for (int i = 0; i < NUM_OF_PORTS; i++) begin
                if (gnt[p][i]) gnt_idx[p] = port_id_t'(i);
            end
            in_grant = in_grant | gnt[p];
        end
    end

    always_comb begin
        err_d   = err_q;
        valid_d = '0;
        for (int p = 0; p < NUM_OF_PORTS; p++) begin
            state_d[p]  = state_q[p];
            owner_d[p]  = owner_q[p];
            rr_d[p]     = rr_q[p];
            credit_d[p] = credit_q[p];
            sel_d[p]    = sel_q[p];
`ifdef SW_ALLOC_STATS_EN
            pkt_d[p]    = pkt_q[p];
`endif
            if (|gnt[p]) begin
                valid_d[p] = 1'b1;
                sel_d[p]   = gnt_idx[p];
                if (state_q[p] == O_IDLE) begin
                    if (sa.i_tail[gnt_idx[p]]) begin
                        rr_d[p] = next_port(gnt_idx[p]);
                    end else begin
                        state_d[p] = O_LOCKED;
                        owner_d[p] = gnt_idx[p];
                    end
                end else if (sa.i_tail[gnt_idx[p]]) begin
                    state_d[p] = O_IDLE;
                    rr_d[p]    = next_port(owner_q[p]);
                end
`ifdef SW_ALLOC_STATS_EN
                if (sa.i_tail[gnt_idx[p]] && (pkt_q[p] != 16'hFFFF)) begin
                    pkt_d[p] = pkt_q[p] + 16'd1;
                end
`endif
            end
            // Grant and return together cancel out.
            case ({|gnt[p], sa.i_credit_ret[p]})
                2'b10: credit_d[p] = credit_q[p] - CNT_W'(1);
                2'b01: begin
                    if (credit_q[p] == CreditFull) err_d = 1'b1;
                    else                           credit_d[p] = credit_q[p] + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q   <= 1'b0;
            valid_q <= '0;
            for (int p = 0; p < NUM_OF_PORTS; p++) begin
                state_q[p]  <= O_IDLE;
                owner_q[p]  <= '0;
                rr_q[p]     <= '0;
                credit_q[p] <= CreditFull;
                sel_q[p]    <= '0;
`ifdef SW_ALLOC_STATS_EN
                pkt_q[p]    <= '0;
`endif
            end
        end else begin
            err_q   <= err_d;
            valid_q <= valid_d;
            for (int p = 0; p < NUM_OF_PORTS; p++) begin
                state_q[p]  <= state_d[p];
                owner_q[p]  <= owner_d[p];
                rr_q[p]     <= rr_d[p];
                credit_q[p] <= credit_d[p];
                sel_q[p]    <= sel_d[p];
`ifdef SW_ALLOC_STATS_EN
                pkt_q[p]    <= pkt_d[p];
`endif
            end
        end
    end

    always_comb begin
        sa.o_in_grant   = in_grant;
        sa.o_xbar_valid = valid_q;
        sa.o_credit_err = err_q;
        for (int p = 0; p < NUM_OF_PORTS; p++) begin
            sa.o_xbar_sel[p] = sel_q[p];
`ifdef SW_ALLOC_STATS_EN
            sa.o_pkt_cnt[p]  = pkt_q[p];
`endif
        end
    end

endmodule

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 Parameter: CREDIT_DEPTH, default 4, downstream buffer slots per output port.
REQ-002 Parameter: CNT_W, default $clog2(CREDIT_DEPTH+1), credit counter width.
REQ-003 Clocking: one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 i_req[NUM_OF_PORTS]  in  1 each  input port holds a flit at the head of its buffer.
REQ-007 i_target_port[NUM_OF_PORTS]  in  3 each  route-computed output port id; NONE_PORT or any id >= NUM_OF_PORTS is invalid.
REQ-008 i_tail[NUM_OF_PORTS]  in  1 each  head-of-buffer flit is a tail flit; a head+tail flit is a single-flit packet.
REQ-009 i_credit_ret[NUM_OF_PORTS]  in  1 each  downstream of that output freed one slot.
REQ-010 o_in_grant[NUM_OF_PORTS]  out  1 each  flit consumed this cycle; combinational.
REQ-011 o_xbar_valid[NUM_OF_PORTS]  out  1 each  output carries a flit next cycle; registered.
REQ-012 o_xbar_sel[NUM_OF_PORTS]  out  3 each  input index driving that output; registered.
REQ-013 o_credit_err  out  1  sticky flag: a credit was returned with the counter already at CREDIT_DEPTH.

Function
REQ-014 Each output runs an independent FSM with states O_IDLE and O_LOCKED, an owner register, and a round-robin pointer.
REQ-015 An input is eligible for output p when i_req=1, i_target_port=p, and the credit count of p is greater than 0; inputs with invalid targets are never eligible.
REQ-016 In O_IDLE, output p grants one eligible input, searching from the RR pointer upward with wrap-around from NUM_OF_PORTS-1 to 0.
REQ-017 O_IDLE grant of a non-tail flit: go to O_LOCKED, owner = granted input.
REQ-018 O_IDLE grant of a head+tail flit: stay in O_IDLE; RR pointer = granted+1 mod NUM_OF_PORTS.
REQ-019 In O_LOCKED, output p grants only the owner, and only when the owner is eligible; all other requesters for p are stalled.
REQ-020 O_LOCKED grant with i_tail=1: go to O_IDLE; RR pointer = owner+1 mod NUM_OF_PORTS.
REQ-021 The RR pointer changes only on packet completion, never on body flits.
REQ-022 Owner stalls (i_req=0 or credit=0): output stays O_LOCKED; no grant is issued and no timeout applies.
REQ-023 An input receives at most one grant per cycle; o_in_grant[i] is the OR over outputs of the grant to i.
REQ-024 On a grant by p to i, the next cycle shows o_xbar_valid[p]=1 and o_xbar_sel[p]=i; otherwise o_xbar_valid[p]=0 and o_xbar_sel[p] holds its value.
REQ-025 Credit counter per output: decrement on grant, increment on i_credit_ret.
REQ-026 Grant and credit return in the same cycle: counter unchanged.
REQ-027 Credit return at CREDIT_DEPTH: counter saturates and o_credit_err is set until reset.
REQ-028 At credit=0, no grant is issued for that output, even to the owner.
REQ-029 Latency: request to o_in_grant is 0 cycles; request to o_xbar_valid is 1 cycle.

Reset
REQ-030 While rst_n=0 at a clk edge, every FSM goes to O_IDLE, owners and RR pointers to 0, credits to CREDIT_DEPTH, o_xbar_valid and o_xbar_sel to 0, and o_credit_err to 0.
REQ-031 While rst_n=0, o_in_grant is forced to 0.
REQ-032 Reset mid-packet abandons the lock with no completion side effects.

Configuration
REQ-033 Macro SW_ALLOC_STATS_EN defined: add output o_pkt_cnt[NUM_OF_PORTS], 16 bits each, counting completed packets per output; it saturates at 0xFFFF and resets to 0.
REQ-034 Macro SW_ALLOC_STATS_EN undefined: the port and its counters are absent; all other behaviour is identical.

Structure
REQ-035 router_pkg contains NUM_OF_PORTS, NONE_PORT, the port-id type, and the sa_state_t enum (O_IDLE, O_LOCKED).
REQ-036 One sub-module, rr_arbiter (request vector plus pointer in, one-hot grant out, combinational), is instantiated once per output.

Verification
REQ-037 Scenario: inputs 0 and 2 each send a 1-flit packet to output 1 every cycle, pointer=0 -> grants alternate 0,2,0,2 and o_xbar_sel[1] follows one cycle later.
REQ-038 Scenario: input 3 sends a 4-flit packet to output 0 while input 1 requests output 0 from cycle 1 -> input 1 stalls until the tail of input 3 is granted, then input 1 is granted the next cycle.
REQ-039 Scenario: CREDIT_DEPTH=4, no credit return, input 0 streams to output 2 -> exactly 4 grants, then stall; one i_credit_ret[2] -> exactly one more grant.
REQ-040 Scenario: grant and i_credit_ret on output 4 in the same cycle at credit=2 -> credit stays 2; a return at credit=4 -> o_credit_err=1 and credit stays 4.
REQ-041 Scenario: rst_n=0 for one cycle in the middle of a locked 3-flit packet -> output is O_IDLE, credits are full, and a new requester is granted in the first cycle after reset.
REQ-042 Scenario: i_target_port=NONE_PORT with i_req=1 -> no grant and no xbar_valid, for 10 cycles.
